fpu_round_sched: RTL and testbench



---
 rtl/fpu_round_sched.sv | 136 +++++++++++++
 tb/tb_fpu_round_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_round_sched.sv
// fpu_round_sched: round-robin sequencer for the shared FPU rounder.
// Grants A/B, decodes the rounding mode, registers and returns the result.
module fpu_round_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [39:0] a_data,
    input  logic [2:0]  a_rm,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [39:0] b_data,
    input  logic [2:0]  b_rm,
    input  logic [2:0]  frm,
    output logic [39:0] rnd_data,
    output logic [4:0]  rnd_mode,
    input  logic [31:0] rnd_res,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_tag,
    output logic        out_nv_rm
);

    // One-hot strobe positions seen by the rounder.
    localparam logic [4:0] M_RTZ = 5'b00001;
    localparam logic [4:0] M_RNE = 5'b00010;
    localparam logic [4:0] M_RDN = 5'b00100;
    localparam logic [4:0] M_RUP = 5'b01000;
    localparam logic [4:0] M_RMM = 5'b10000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_b_q;
    logic [39:0] rnd_data_q;
    logic [4:0]  rnd_mode_q;
    logic [31:0] out_result_q;
    logic        out_tag_q;
    logic        out_nv_q;

    logic        a_rdy, b_rdy, grant;
    logic [2:0]  sel_rm, eff_rm;
    logic [4:0]  mode_d;
    logic        nv_d;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and arbitration; A wins ties unless it won last.
    always_comb begin
        state_d = state_q;
        a_rdy   = 1'b0;
        b_rdy   = 1'b0;
        unique case (state_q)
            IDLE: begin
                a_rdy = a_valid & (~b_valid | last_b_q);
                b_rdy = b_valid & (~a_valid | ~last_b_q);
                if (a_rdy | b_rdy) begin
                    state_d = ROUND;
                end
            end
            ROUND: state_d = RESP;
            RESP: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Resolve dynamic mode and map it onto the rounder strobes.
    always_comb begin
        sel_rm = b_rdy ? b_rm : a_rm;
        eff_rm = (sel_rm == 3'b111) ? frm : sel_rm;
        mode_d = M_RNE;
        nv_d   = 1'b0;
        case (eff_rm)
            3'b000:  mode_d = M_RNE;
            3'b001:  mode_d = M_RTZ;
            3'b010:  mode_d = M_RDN;
            3'b011:  mode_d = M_RUP;
            3'b100:  mode_d = M_RMM;
            default: begin
                mode_d = M_RNE;
                nv_d   = 1'b1;
            end
        endcase
    end

    assign grant = a_rdy | b_rdy;

    // Capture request on grant, result at the end of ROUND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b_q     <= 1'b1;
            rnd_data_q   <= '0;
            rnd_mode_q   <= '0;
            out_tag_q    <= 1'b0;
            out_nv_q     <= 1'b0;
            out_result_q <= '0;
        end else begin
            if (grant) begin
                last_b_q   <= b_rdy;
                rnd_data_q <= b_rdy ? b_data : a_data;
                rnd_mode_q <= mode_d;
                out_tag_q  <= b_rdy;
                out_nv_q   <= nv_d;
            end
            if (state_q == ROUND) begin
                out_result_q <= rnd_res;
            end
        end
    end

    assign a_ready    = a_rdy & rst_n;
    assign b_ready    = b_rdy & rst_n;
    assign out_valid  = (state_q == RESP);
    assign rnd_data   = rnd_data_q;
    assign rnd_mode   = rnd_mode_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign out_nv_rm  = out_nv_q;

endmodule

// File: tb/tb_fpu_round_sched.sv
// tb_fpu_round_sched: scoreboard bench with a behavioural rounder.
// Expected results are queued at grant and compared on output handshake.
module tb_fpu_round_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [39:0] a_data, b_data, rnd_data;
    logic [2:0]  a_rm, b_rm, frm;
    logic [4:0]  rnd_mode;
    logic [31:0] rnd_res, out_result;
    logic        out_valid, out_ready, out_tag, out_nv_rm;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        tag;
        logic        nv;
        logic [31:0] res;
    } exp_t;

    exp_t        sb[$];
    logic [42:0] a_src[$];
    logic [42:0] b_src[$];
    logic [32:0] res_log[$];
    logic [5:0]  mode_log[$];

    logic        a_hs = 1'b0, b_hs = 1'b0;
    logic        pend = 1'b0, lat_arm = 1'b0, prev_hold = 1'b0;
    logic [39:0] pend_data;
    logic [4:0]  pend_mode;
    logic [31:0] prev_res;
    logic        prev_tag, prev_nv;
    int          cyc = 0, grant_cyc = 0;

    fpu_round_sched dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready),
        .a_data(a_data), .a_rm(a_rm),
        .b_valid(b_valid), .b_ready(b_ready),
        .b_data(b_data), .b_rm(b_rm),
        .frm(frm),
        .rnd_data(rnd_data), .rnd_mode(rnd_mode),
        .rnd_res(rnd_res),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .out_nv_rm(out_nv_rm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Returns {nv, one-hot mode {RMM,RUP,RDN,RNE,RTZ}}.
    function automatic logic [5:0] dec(input logic [2:0] rm,
                                       input logic [2:0] f);
        logic [2:0] e;
        e = (rm == 3'b111) ? f : rm;
        case (e)
            3'b000:  return {1'b0, 5'b00010};
            3'b001:  return {1'b0, 5'b00001};
            3'b010:  return {1'b0, 5'b00100};
            3'b011:  return {1'b0, 5'b01000};
            3'b100:  return {1'b0, 5'b10000};
            default: return {1'b1, 5'b00010};
        endcase
    endfunction

    // Behavioural rounder: 26-bit mantissa down to 23 bits.
    function automatic logic [31:0] rmodel(input logic [39:0] d,
                                           input logic [4:0] m);
        logic [22:0] k;
        logic g, st, s, inc;
        k   = d[39:17];
        g   = d[16];
        st  = |d[15:14];
        s   = d[5];
        inc = 1'b0;
        if (m[1])      inc = g & (st | k[0]);
        else if (m[3]) inc = (g | st) & ~s;
        else if (m[2]) inc = (g | st) & s;
        else if (m[4]) inc = g;
        return {s, d[13:6], k + {22'd0, inc}};
    endfunction

    function automatic logic [39:0] rpay();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[39:0];
    endfunction

    assign rnd_res = rmodel(rnd_data, rnd_mode);

    // Monitor: protocol checks, scoreboard push at grant, pop at output.
    always @(negedge clk) begin
        logic  in_round;
        logic [39:0] d;
        logic [2:0]  rm;
        logic [5:0]  nm;
        exp_t        e;
        cyc++;
        if (!rst_n) begin
            sb.delete();
            pend      = 1'b0;
            lat_arm   = 1'b0;
            prev_hold = 1'b0;
            a_hs      = 1'b0;
            b_hs      = 1'b0;
        end else begin
            in_round = pend;
            if (pend) begin
                chk("rnd_mode", rnd_mode, pend_mode);
                chk("rnd_data", rnd_data, pend_data);
                mode_log.push_back({out_nv_rm, rnd_mode});
                pend = 1'b0;
            end
            if (lat_arm && out_valid) begin
                chk("latency", cyc - grant_cyc, 2);
                lat_arm = 1'b0;
            end
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_res", out_result, prev_res);
                chk("hold_tag", out_tag, prev_tag);
                chk("hold_nv", out_nv_rm, prev_nv);
            end
            if (a_ready | b_ready) begin
                chk("rdy_onehot", a_ready & b_ready, 0);
                chk("rdy_idle", out_valid | in_round, 0);
            end
            a_hs = a_valid & a_ready;
            b_hs = b_valid & b_ready;
            if (a_hs | b_hs) begin
                d  = b_hs ? b_data : a_data;
                rm = b_hs ? b_rm : a_rm;
                nm = dec(rm, frm);
                sb.push_back({b_hs, nm[5], rmodel(d, nm[4:0])});
                pend      = 1'b1;
                pend_data = d;
                pend_mode = nm[4:0];
                grant_cyc = cyc;
                lat_arm   = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_result", out_result, e.res);
                    chk("out_tag", out_tag, e.tag);
                    chk("out_nv_rm", out_nv_rm, e.nv);
                    res_log.push_back({out_tag, out_result});
                end
            end
            prev_hold = out_valid & ~out_ready;
            prev_res  = out_result;
            prev_tag  = out_tag;
            prev_nv   = out_nv_rm;
        end
    end

    // Requester A: holds valid/data until handshake.
    initial begin
        a_valid = 1'b0; a_data = '0; a_rm = '0;
        forever begin
            @(posedge clk); #1;
            if (a_hs) a_valid = 1'b0;
            if (!a_valid && a_src.size() > 0) begin
                {a_data, a_rm} = a_src.pop_front();
                a_valid = 1'b1;
            end
        end
    end

    // Requester B: holds valid/data until handshake.
    initial begin
        b_valid = 1'b0; b_data = '0; b_rm = '0;
        forever begin
            @(posedge clk); #1;
            if (b_hs) b_valid = 1'b0;
            if (!b_valid && b_src.size() > 0) begin
                {b_data, b_rm} = b_src.pop_front();
                b_valid = 1'b1;
            end
        end
    end

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (a_src.size() == 0 && b_src.size() == 0 &&
                !a_valid && !b_valid && sb.size() == 0 &&
                !out_valid && !pend) return;
        end
        chk("timeout", 0, 1);
    endtask

    task automatic last_tags(input string tag, input int n,
                             input logic [3:0] exp);
        chk({tag, "_n"}, res_log.size(), n);
        for (int i = 0; i < n && i < res_log.size(); i++)
            chk(tag, res_log[i][32], exp[i]);
    endtask

    initial begin
        logic [39:0] pay;
        rst_n = 1'b0; out_ready = 1'b1; frm = 3'b000;
        for (int i = 0; i < 2; i++) begin
            a_src.push_back({rpay(), 3'b000});
            b_src.push_back({rpay(), 3'($urandom_range(4, 0))});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_nv", out_nv_rm, 0);
        chk("rst_rnd_data", rnd_data, 0);
        chk("rst_rnd_mode", rnd_mode, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        wait_done();
        last_tags("rr_tag", 4, 4'b1010);

        res_log.delete(); mode_log.delete();
        b_src.push_back({rpay(), 3'b001});
        wait_done();
        last_tags("lone_b", 1, 4'b0001);

        res_log.delete(); mode_log.delete();
        pay = {26'h000000C, 8'h80, 6'b000000};
        a_src.push_back({pay, 3'b000});
        wait_done();
        chk("rne_res", res_log.size() > 0 ? res_log[0] : 0, 33'h040000002);
        chk("rne_mode", mode_log.size() > 0 ? mode_log[0] : 0, 6'b000010);

        res_log.delete(); mode_log.delete();
        frm = 3'b011;
        a_src.push_back({rpay(), 3'b111});
        wait_done();
        a_src.push_back({rpay(), 3'b101});
        wait_done();
        frm = 3'b110;
        a_src.push_back({rpay(), 3'b111});
        wait_done();
        chk("mode_n", mode_log.size(), 3);
        if (mode_log.size() == 3) begin
            chk("mode_dyn_rup", mode_log[0], 6'b001000);
            chk("mode_ill_101", mode_log[1], 6'b100010);
            chk("mode_ill_frm", mode_log[2], 6'b100010);
        end
        for (int i = 0; i < 8; i++) begin
            frm = 3'($urandom_range(4, 0));
            a_src.push_back({rpay(), 3'($urandom_range(7, 0))});
            b_src.push_back({rpay(), 3'($urandom_range(7, 0))});
            wait_done();
        end

        out_ready = 1'b0;
        a_src.push_back({rpay(), 3'b010});
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        chk("bp_valid", out_valid, 1);
        b_src.push_back({rpay(), 3'b011});
        repeat (5) begin
            @(negedge clk);
            chk("bp_b_ready", b_ready, 0);
        end
        chk("bp_b_pend", b_valid, 1);
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_grant", b_ready, 1);
        wait_done();

        res_log.delete();
        a_src.push_back({rpay(), 3'b000});
        for (int i = 0; i < 50 && !a_hs; i++) @(negedge clk);
        chk("rr_hs_seen", a_hs, 1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_rnd_mode", rnd_mode, 0);
        chk("arst_rnd_data", rnd_data, 0);
        chk("arst_out_result", out_result, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("arst_no_out", out_valid, 0);
        end
        chk("arst_no_log", res_log.size(), 0);
        a_src.push_back({rpay(), 3'b100});
        b_src.push_back({rpay(), 3'b000});
        wait_done();
        last_tags("arst_tag", 2, 4'b0010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
